axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Two-master to one-slave AXI3 read-channel arbiter between the caches and the external AXI read port. Master 0 is the data cache read port and master 1 is the instruction cache read port. It replaces the read half of the generated crossbar with a small, verifiable block. Write traffic bypasses it and is not handled here.

## Interface
Parameters:
- `ID_W`, 4, AXI ID width
- `ADDR_W`, 32, address width
- `DATA_W`, 32, read data width

Ports:
- `aclk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m0_ar*`  in  AXI3 AR bundle from master 0 (dcache):
  - `m0_arid` ID_W, `m0_araddr` ADDR_W, `m0_arlen` 4, `m0_arsize` 3
  - `m0_arburst` 2, `m0_arlock` 2, `m0_arcache` 4, `m0_arprot` 3, `m0_arvalid` 1
- `m0_arready`  out  1  AR accepted from master 0
- `m0_rid` / `m0_rdata` / `m0_rresp` / `m0_rlast` / `m0_rvalid`  out  ID_W / DATA_W / 2 / 1 / 1  R channel to master 0
- `m0_rready`  in  1  master 0 accepts R beat
- `m1_*`  same set as `m0_*`, for master 1 (icache)
- `s_ar*`  out  AR bundle to the slave, same widths as `m0_ar*`, including `s_arvalid`
- `s_arready`  in  1  slave accepts AR
- `s_rid` / `s_rdata` / `s_rresp` / `s_rlast` / `s_rvalid`  in  R channel from the slave
- `s_rready`  out  1  R accept to the slave

## Operation
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE. Exactly one transaction is outstanding at a time.
- **IDLE**
  - If any `mX_arvalid` is high, grant one master using round-robin.
  - `last_grant` resets to 1, so master 0 wins the first contention.
  - When only one master requests, that master is granted regardless of `last_grant`.
  - In the grant cycle, assert `mX_arready` combinationally for the granted master only.
  - Capture that master's AR fields into the AR register, update `grant` and `last_grant`, and go to ADDR.
- **ADDR**
  - `s_arvalid`=1 and `s_ar*` = captured fields, held stable until `s_arready`.
  - On `s_arvalid & s_arready`, go to DATA.
- **DATA**
  - Route by `grant`, not by `rid`: `m<grant>_r*` = `s_r*`, and `s_rready` = `m<grant>_rready`.
  - The non-granted master sees `rvalid`=0.
  - On `s_rvalid & s_rready & s_rlast`, go to IDLE.
- `mX_arready` is 0 in ADDR and DATA. A request that arrives meanwhile waits; it is never dropped.
- `rid`, `rresp` and `rdata` pass through unmodified. SLVERR/DECERR beats are forwarded like any other beat.
- `flush` from the icache has no effect here. A started burst always completes, and the cache discards the data itself.
- No timeout exists: a slave that never asserts `rlast` hangs the arbiter by design.
- **Reset mid-burst:** state goes to IDLE and the AR register clears. The slave is reset by the same `rst`.

## Timing
- Reset values:
  - `s_arvalid`=0, `s_ar*`=0, `s_rready`=0
  - `m0/m1_arready`=0, `m0/m1_rvalid`=0, `m0/m1_r*`=0
  - `grant`=0, `last_grant`=1
- AR latency: master handshake in cycle N; `s_arvalid` high from cycle N+1, because the AR register is flopped.
- R path is fully combinational: zero added latency, and `s_rready` follows `m<grant>_rready` in the same cycle.
- After the last beat in cycle M, state is IDLE in M+1, and the next grant can happen in M+1. Minimum gap between bursts is one cycle.
- Both `arvalid` high in IDLE: grant goes to `~last_grant`. Alternating, so no starvation.
- `s_arready` high already in the first ADDR cycle: go to DATA in the next cycle.
- Slave R data arriving in the same cycle as the AR handshake is illegal for AXI and not handled.

## Structure
- Shared package `axi_arb_pkg`:
  - state enum `{IDLE, ADDR, DATA}`
  - `AXI_ID_W`, `AXI_ADDR_W`, `AXI_DATA_W`
  - AR bundle struct
- Sub-module `rr_arbiter_2`: combinational 2-way round-robin pick from `req[1:0]` and `last_grant`, giving `gnt` and `valid`.
- Everything else (FSM, AR register, R mux) lives in `axi_read_arbiter`.

## Test plan
- **Single master 0:** `araddr`=0x1FC0_0000, `arlen`=3. Expect `m0_arready` for 1 cycle, `s_arvalid` the next cycle with identical fields, 4 beats routed to `m0`, `m1_rvalid`=0 throughout.
- **Both request in the same cycle after reset:** master 0 granted first. Master 1 is granted in the cycle after master 0's `rlast` beat, and master 1 `arvalid` is held low-ready until then.
- **Back-to-back contention over 4 rounds:** grants alternate 0,1,0,1, and each `araddr` appears on `s_araddr` in order.
- **Backpressure:** `s_arready` low for 5 cycles, then `m1_rready` toggling 1,0,1,0 over a 2-beat burst. Expect `s_ar*` stable while waiting, `s_rready` mirroring `m1_rready`, and no lost or duplicated beats.
- **Reset mid-burst:** assert `rst` during DATA beat 2 of 4. Every output is 0 immediately (asynchronous), and the state is IDLE after deassert.
- **Error response:** `rresp`=2'b10 with `rid`=0x1 forwarded unchanged to master 1.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and widths for the two-master AXI3 read arbiter.
package axi_arb_pkg;

   localparam int unsigned AXI_ID_W   = 4;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 32;

   // Arbiter control states; one transaction outstanding at a time.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   // AR bundle attributes that have fixed AXI3 widths (id/addr are parameterised).
   typedef struct packed {
      logic [3:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic [1:0] lock;
      logic [3:0] cache;
      logic [2:0] prot;
   } ar_attr_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: the loser of the previous grant wins a tie.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt,
   output logic       valid
);

   // Lone requester wins outright; on contention favour the other side of last_grant.
   always_comb begin
      valid = |req;
      gnt   = 1'b0;
      if (req == 2'b11) begin
         gnt = ~last_grant;
      end else begin
         gnt = req[1];
      end
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI3 read-channel arbiter (m0 = dcache, m1 = icache).
module axi_read_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned ID_W   = AXI_ID_W,
   parameter int unsigned ADDR_W = AXI_ADDR_W,
   parameter int unsigned DATA_W = AXI_DATA_W
) (
   input  logic              aclk,
   input  logic              rst,
   // master 0 AR
   input  logic [ID_W-1:0]   m0_arid,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [3:0]        m0_arlen,
   input  logic [2:0]        m0_arsize,
   input  logic [1:0]        m0_arburst,
   input  logic [1:0]        m0_arlock,
   input  logic [3:0]        m0_arcache,
   input  logic [2:0]        m0_arprot,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   // master 0 R
   output logic [ID_W-1:0]   m0_rid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   // master 1 AR
   input  logic [ID_W-1:0]   m1_arid,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [3:0]        m1_arlen,
   input  logic [2:0]        m1_arsize,
   input  logic [1:0]        m1_arburst,
   input  logic [1:0]        m1_arlock,
   input  logic [3:0]        m1_arcache,
   input  logic [2:0]        m1_arprot,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   // master 1 R
   output logic [ID_W-1:0]   m1_rid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   // slave AR
   output logic [ID_W-1:0]   s_arid,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [3:0]        s_arlen,
   output logic [2:0]        s_arsize,
   output logic [1:0]        s_arburst,
   output logic [1:0]        s_arlock,
   output logic [3:0]        s_arcache,
   output logic [2:0]        s_arprot,
   output logic              s_arvalid,
   input  logic              s_arready,
   // slave R
   input  logic [ID_W-1:0]   s_rid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   input  logic              s_rvalid,
   output logic              s_rready
);

   state_t            state;
   state_t            state_nxt;
   logic              grant;
   logic              last_grant;
   logic              pick_gnt;
   logic              pick_valid;
   logic              ar_load;
   logic [ID_W-1:0]   ar_id;
   logic [ADDR_W-1:0] ar_addr;
   ar_attr_t          ar_attr;
   ar_attr_t          m0_attr;
   ar_attr_t          m1_attr;

   assign m0_attr = '{len: m0_arlen, size: m0_arsize, burst: m0_arburst,
                      lock: m0_arlock, cache: m0_arcache, prot: m0_arprot};
   assign m1_attr = '{len: m1_arlen, size: m1_arsize, burst: m1_arburst,
                      lock: m1_arlock, cache: m1_arcache, prot: m1_arprot};

   rr_arbiter_2 u_rr (
      .req        ({m1_arvalid, m0_arvalid}),
      .last_grant (last_grant),
      .gnt        (pick_gnt),
      .valid      (pick_valid)
   );

   // State register.
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant owner and round-robin history, updated only on an AR handshake.
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else if (ar_load) begin
         grant      <= pick_gnt;
         last_grant <= pick_gnt;
      end
   end

   // AR register: holds the winning request stable for the slave.
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         ar_id   <= '0;
         ar_addr <= '0;
         ar_attr <= '0;
      end else if (ar_load) begin
         ar_id   <= pick_gnt ? m1_arid   : m0_arid;
         ar_addr <= pick_gnt ? m1_araddr : m0_araddr;
         ar_attr <= pick_gnt ? m1_attr   : m0_attr;
      end
   end

   // Next state and AR-side handshakes; arready is held low while reset is asserted.
   always_comb begin
      state_nxt  = state;
      ar_load    = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      s_arvalid  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid && !rst) begin
               ar_load    = 1'b1;
               m0_arready = ~pick_gnt;
               m1_arready = pick_gnt;
               state_nxt  = ADDR;
            end
         end
         ADDR: begin
            s_arvalid = 1'b1;
            if (s_arready) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (s_rvalid && s_rready && s_rlast) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Captured AR fields drive the slave directly.
   assign s_arid    = ar_id;
   assign s_araddr  = ar_addr;
   assign s_arlen   = ar_attr.len;
   assign s_arsize  = ar_attr.size;
   assign s_arburst = ar_attr.burst;
   assign s_arlock  = ar_attr.lock;
   assign s_arcache = ar_attr.cache;
   assign s_arprot  = ar_attr.prot;

   // R path: steer by grant during DATA, zeros to everyone otherwise.
   always_comb begin
      m0_rid    = '0;
      m0_rdata  = '0;
      m0_rresp  = '0;
      m0_rlast  = 1'b0;
      m0_rvalid = 1'b0;
      m1_rid    = '0;
      m1_rdata  = '0;
      m1_rresp  = '0;
      m1_rlast  = 1'b0;
      m1_rvalid = 1'b0;
      s_rready  = 1'b0;
      if (state == DATA) begin
         if (grant) begin
            m1_rid    = s_rid;
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
            m1_rlast  = s_rlast;
            m1_rvalid = s_rvalid;
            s_rready  = m1_rready;
         end else begin
            m0_rid    = s_rid;
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
            m0_rlast  = s_rlast;
            m0_rvalid = s_rvalid;
            s_rready  = m0_rready;
         end
      end
   end

endmodule
